// File: rtl/vader_pkg.sv
// Shared codes for the dictionary-attack controller: external state/LED codes,
// the internal FSM state enum and the mapping from internal to external view.
package vader_pkg;

  localparam logic [2:0] ST_WAIT    = 3'd0;
  localparam logic [2:0] ST_DECRYPT = 3'd1;
  localparam logic [2:0] ST_DICT    = 3'd2;
  localparam logic [2:0] ST_SUCCESS = 3'd3;
  localparam logic [2:0] ST_FAIL    = 3'd4;

  localparam logic [2:0] LED_WAIT = 3'b011;
  localparam logic [2:0] LED_OK   = 3'b010;
  localparam logic [2:0] LED_FAIL = 3'b001;
  localparam logic [2:0] LED_OFF  = 3'b000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_HASH,
    S_RD_KEY,
    S_RD_CT,
    S_DEC_REQ,
    S_DEC_WAIT,
    S_DICT_RD,
    S_ENC_REQ,
    S_ENC_WAIT,
    S_SUCCESS,
    S_FAIL
  } fsm_t;

  function automatic logic [2:0] ext_state(input fsm_t s);
    case (s)
      S_DEC_REQ, S_DEC_WAIT:            return ST_DECRYPT;
      S_DICT_RD, S_ENC_REQ, S_ENC_WAIT: return ST_DICT;
      S_SUCCESS:                        return ST_SUCCESS;
      S_FAIL:                           return ST_FAIL;
      default:                          return ST_WAIT;
    endcase
  endfunction

  function automatic logic [2:0] led_code(input logic [2:0] st);
    case (st)
      ST_WAIT:    return LED_WAIT;
      ST_SUCCESS: return LED_OK;
      ST_FAIL:    return LED_FAIL;
      default:    return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/dict_attack_ctrl_if.sv
// BRAM read port and AES start/done handshake of the dictionary-attack controller.
// master = controller side, slave = memory / AES core side.
interface dict_attack_ctrl_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 8
) ();

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              aes_start;
  logic              aes_decrypt;
  logic [DATA_W-1:0] aes_data;
  logic [DATA_W-1:0] aes_key;
  logic              aes_done;
  logic [DATA_W-1:0] aes_result;

  modport master (
    output mem_en, mem_addr, aes_start, aes_decrypt, aes_data, aes_key,
    input  mem_dout, aes_done, aes_result
  );

  modport slave (
    input  mem_en, mem_addr, aes_start, aes_decrypt, aes_data, aes_key,
    output mem_dout, aes_done, aes_result
  );

endinterface

// File: rtl/dict_attack_ctrl_bram_reader.sv
// Single-word BRAM read sequencer: latches the address on go, holds it until the
// data has had RD_LAT cycles to appear, and flags the capture cycle with done.
module bram_reader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              done
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic              en_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg   <= 1'b0;
      addr_reg <= '0;
      cnt_reg  <= '0;
    end else if (go) begin
      en_reg   <= 1'b1;
      addr_reg <= addr;
      cnt_reg  <= CNT_W'(RD_LAT);
    end else if (en_reg) begin
      // Data is valid once the countdown reaches zero; release the port after that cycle.
      if (cnt_reg == '0) begin
        en_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  assign mem_en   = en_reg;
  assign mem_addr = addr_reg;
  assign done     = en_reg && (cnt_reg == '0);

endmodule

// File: rtl/dict_attack_ctrl.sv
// Password-recovery controller: loads hash/key/ciphertext, tries one decrypt, then an
// encrypt-and-compare dictionary sweep. Define AES_TIMEOUT_EN to add the AES watchdog.
module dict_attack_ctrl
  import vader_pkg::*;
#(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       HASH_ADDR   = 0,
  parameter int unsigned       KEY_ADDR    = 1,
  parameter int unsigned       CT_ADDR     = 2,
  parameter int unsigned       DICT_START  = 3,
  parameter int unsigned       DICT_SIZE   = 4,
  parameter int unsigned       RD_LAT      = 1,
  parameter logic [DATA_W-1:0] KNOWN_PT    = "Discombobulateme",
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  dict_attack_ctrl_if.master  bus,
  output logic [2:0]          state,
  output logic [2:0]          led,
  output logic [ADDR_W-1:0]   found_idx,
  output logic                timeout
);

  localparam int IDX_W = (DICT_SIZE == 0) ? 1 : $clog2(DICT_SIZE + 1);

  if ((64'(DICT_START) + 64'(DICT_SIZE)) > (64'd1 << ADDR_W)) begin : g_bad_dict
    $error("dictionary does not fit in the BRAM address space");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  fsm_t              fsm_reg;
  logic [2:0]        state_reg;
  logic [2:0]        led_reg;
  logic [ADDR_W-1:0] found_idx_reg;
  logic              timeout_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] hash_reg;
  logic [DATA_W-1:0] key_reg;
  logic [DATA_W-1:0] ct_reg;
  logic              aes_start_reg;
  logic              aes_decrypt_reg;
  logic [DATA_W-1:0] aes_data_reg;

  logic              rd_state;
  logic              rd_go;
  logic              rd_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  idx_inc;
  logic              tmo_hit;

  assign rd_state = (fsm_reg == S_RD_HASH) || (fsm_reg == S_RD_KEY) ||
                    (fsm_reg == S_RD_CT)   || (fsm_reg == S_DICT_RD);
  assign rd_go    = rd_state && !bus.mem_en;
  assign idx_inc  = idx_reg + IDX_W'(1);

  always_comb begin
    rd_addr = ADDR_W'(HASH_ADDR);
    case (fsm_reg)
      S_RD_KEY:  rd_addr = ADDR_W'(KEY_ADDR);
      S_RD_CT:   rd_addr = ADDR_W'(CT_ADDR);
      S_DICT_RD: rd_addr = ADDR_W'(DICT_START) + ADDR_W'(idx_reg);
      default:   ;
    endcase
  end

  bram_reader #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_reader (
    .clk      (clk),
    .reset    (reset),
    .go       (rd_go),
    .addr     (rd_addr),
    .mem_en   (bus.mem_en),
    .mem_addr (bus.mem_addr),
    .done     (rd_done)
  );

`ifdef AES_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             aes_wait;

  assign aes_wait = (fsm_reg == S_DEC_WAIT) || (fsm_reg == S_ENC_WAIT);

  // Cleared in the request cycle so it reads zero in the cycle aes_start is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
    end else if ((fsm_reg == S_DEC_REQ) || (fsm_reg == S_ENC_REQ)) begin
      tmo_cnt_reg <= '0;
    end else if (aes_wait) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end
  end

  assign tmo_hit = aes_wait && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // External state and LED are registered alongside the FSM so they change on the same edge.
  task automatic go_to(input fsm_t nxt);
    fsm_reg   <= nxt;
    state_reg <= ext_state(nxt);
    led_reg   <= led_code(ext_state(nxt));
  endtask

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg         <= S_IDLE;
      state_reg       <= ST_WAIT;
      led_reg         <= LED_OFF;
      found_idx_reg   <= '0;
      timeout_reg     <= 1'b0;
      idx_reg         <= '0;
      hash_reg        <= '0;
      key_reg         <= '0;
      ct_reg          <= '0;
      aes_start_reg   <= 1'b0;
      aes_decrypt_reg <= 1'b0;
      aes_data_reg    <= '0;
    end else begin
      aes_start_reg <= 1'b0;
      case (fsm_reg)
        S_IDLE, S_SUCCESS, S_FAIL: begin
          if (start) begin
            found_idx_reg <= '0;
            timeout_reg   <= 1'b0;
            go_to(S_RD_HASH);
          end else begin
            go_to(fsm_reg);
          end
        end
        S_RD_HASH: if (rd_done) begin
          hash_reg <= bus.mem_dout;
          go_to(S_RD_KEY);
        end
        S_RD_KEY: if (rd_done) begin
          key_reg <= bus.mem_dout;
          go_to(S_RD_CT);
        end
        S_RD_CT: if (rd_done) begin
          ct_reg <= bus.mem_dout;
          go_to(S_DEC_REQ);
        end
        S_DEC_REQ: begin
          aes_start_reg   <= 1'b1;
          aes_decrypt_reg <= 1'b1;
          aes_data_reg    <= ct_reg;
          go_to(S_DEC_WAIT);
        end
        S_DEC_WAIT: begin
          if (bus.aes_done) begin
            if (bus.aes_result == KNOWN_PT) begin
              found_idx_reg <= '1;
              go_to(S_SUCCESS);
            end else if (DICT_SIZE == 0) begin
              go_to(S_FAIL);
            end else begin
              idx_reg <= '0;
              go_to(S_DICT_RD);
            end
          end else if (tmo_hit) begin
            timeout_reg <= 1'b1;
            go_to(S_FAIL);
          end
        end
        // The dictionary word goes straight into the AES input register.
        S_DICT_RD: if (rd_done) begin
          aes_data_reg <= bus.mem_dout;
          go_to(S_ENC_REQ);
        end
        S_ENC_REQ: begin
          aes_start_reg   <= 1'b1;
          aes_decrypt_reg <= 1'b0;
          go_to(S_ENC_WAIT);
        end
        S_ENC_WAIT: begin
          if (bus.aes_done) begin
            if (bus.aes_result == hash_reg) begin
              found_idx_reg <= ADDR_W'(idx_reg);
              go_to(S_SUCCESS);
            end else if (idx_inc >= IDX_W'(DICT_SIZE)) begin
              go_to(S_FAIL);
            end else begin
              idx_reg <= idx_inc;
              go_to(S_DICT_RD);
            end
          end else if (tmo_hit) begin
            timeout_reg <= 1'b1;
            go_to(S_FAIL);
          end
        end
        default: go_to(S_IDLE);
      endcase
    end
  end

  assign bus.aes_start   = aes_start_reg;
  assign bus.aes_decrypt = aes_decrypt_reg;
  assign bus.aes_data    = aes_data_reg;
  assign bus.aes_key     = key_reg;

  assign state     = state_reg;
  assign led       = led_reg;
  assign found_idx = found_idx_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_dict_attack_ctrl.sv
// Directed bench for dict_attack_ctrl with a behavioural BRAM (latency 1) and AES core.
module tb_dict_attack_ctrl;

  localparam logic [127:0] HASH = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] KEY  = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] CT   = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] KPT  = "Discombobulateme";

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] state;
  logic [2:0] led;
  logic [7:0] found_idx;
  logic       timeout;

  dict_attack_ctrl_if #(.DATA_W(128), .ADDR_W(8)) bus ();

  dict_attack_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .state     (state),
    .led       (led),
    .found_idx (found_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // BRAM model
  logic [127:0] mem [0:255];
  always @(posedge clk) if (bus.mem_en) bus.mem_dout <= mem[bus.mem_addr];

  // read log: one entry per read transaction (rising mem_en)
  logic [7:0] rd_log [0:255];
  int         rd_n = 0;
  logic       mem_en_d = 1'b0;
  always @(posedge clk) begin
    mem_en_d <= bus.mem_en;
    if (bus.mem_en && !mem_en_d) begin
      rd_log[rd_n[7:0]] <= bus.mem_addr;
      rd_n <= rd_n + 1;
    end
  end

  // AES model
  logic [127:0] dec_result = 128'h0;
  logic [127:0] match_word = 128'h0;
  bit           match_en   = 1'b0;
  bit           aes_mute   = 1'b0;
  int           aes_lat    = 3;
  int           aes_cnt    = 0;
  int           n_start    = 0;
  logic [127:0] pending, last_data, last_key;
  logic         last_dec;
  initial begin
    bus.aes_done   = 1'b0;
    bus.aes_result = '0;
  end
  always @(posedge clk) begin
    bus.aes_done <= 1'b0;
    if (aes_cnt > 0) begin
      aes_cnt <= aes_cnt - 1;
      if (aes_cnt == 1) begin
        bus.aes_done   <= 1'b1;
        bus.aes_result <= pending;
      end
    end
    if (bus.aes_start) begin
      n_start   <= n_start + 1;
      last_dec  <= bus.aes_decrypt;
      last_data <= bus.aes_data;
      last_key  <= bus.aes_key;
      if (!aes_mute) aes_cnt <= aes_lat;
      if (bus.aes_decrypt) pending <= dec_result;
      else if (match_en && bus.aes_data == match_word) pending <= HASH;
      else pending <= bus.aes_data ^ bus.aes_key;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] want, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (state === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int s0, r0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (led !== 3'b000) $display("FAIL reset_led: got %b want 000", led); else n_pass++;
    n_checks++; if (bus.mem_en !== 1'b0 || bus.aes_start !== 1'b0) $display("FAIL reset_strobes: mem_en %b aes_start %b want 0 0", bus.mem_en, bus.aes_start); else n_pass++;
    n_checks++; if (found_idx !== 8'h00 || timeout !== 1'b0) $display("FAIL reset_found: found_idx %h timeout %b want 00 0", found_idx, timeout); else n_pass++;
    reset = 1'b0;
    s0 = n_start; r0 = rd_n;
    @(negedge clk);
    n_checks++; if (led !== 3'b011) $display("FAIL release_led: got %b want 011", led); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (state !== 3'd0 || led !== 3'b011) $display("FAIL idle: state %0d led %b want 0 011", state, led); else n_pass++;
    n_checks++; if (n_start != s0 || bus.mem_en !== 1'b0 || rd_n != r0) $display("FAIL idle_quiet: starts %0d reads %0d mem_en %b want 0 0 0", n_start - s0, rd_n - r0, bus.mem_en); else n_pass++;
    $display("reset: state=%0d led=%b", state, led);
  endtask

  task automatic test_trial_decrypt();
    int s0, r0;
    bit ok;
    logic [7:0] exp_a [0:2];
    exp_a[0] = 8'd0; exp_a[1] = 8'd1; exp_a[2] = 8'd2;
    dec_result = KPT; match_en = 1'b0;
    s0 = n_start; r0 = rd_n;
    pulse_start();
    wait_state(3'd1, 40, ok);
    n_checks++; if (!ok) $display("FAIL dec_state1: state %0d never reached 1", state); else n_pass++;
    wait_state(3'd3, 40, ok);
    n_checks++; if (!ok) $display("FAIL dec_success: got state %0d want 3", state); else n_pass++;
    n_checks++; if (led !== 3'b010) $display("FAIL dec_led: got %b want 010", led); else n_pass++;
    n_checks++; if (found_idx !== 8'hFF) $display("FAIL dec_found: got %h want ff", found_idx); else n_pass++;
    n_checks++; if (rd_n - r0 != 3) $display("FAIL dec_nreads: got %0d want 3", rd_n - r0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rd_log[8'(r0 + i)] !== exp_a[i]) $display("FAIL dec_addr%0d: got %0d want %0d", i, rd_log[8'(r0 + i)], exp_a[i]); else n_pass++;
    end
    n_checks++; if (n_start - s0 != 1) $display("FAIL dec_nstart: got %0d want 1", n_start - s0); else n_pass++;
    n_checks++; if (last_dec !== 1'b1 || last_data !== CT || last_key !== KEY) $display("FAIL dec_req: dec %b data %h key %h want 1 %h %h", last_dec, last_data, last_key, CT, KEY); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (state !== 3'd3 || found_idx !== 8'hFF) $display("FAIL dec_hold: state %0d found %h want 3 ff", state, found_idx); else n_pass++;
    $display("trial_decrypt: state=%0d found_idx=%h reads=%0d starts=%0d", state, found_idx, rd_n - r0, n_start - s0);
  endtask

  task automatic test_dict_match();
    int s0, r0;
    bit ok;
    dec_result = ~KPT; match_en = 1'b1; match_word = mem[5];
    s0 = n_start; r0 = rd_n;
    pulse_start();
    n_checks++; if (found_idx !== 8'h00 || state !== 3'd0) $display("FAIL match_restart: found %h state %0d want 00 0", found_idx, state); else n_pass++;
    wait_state(3'd3, 200, ok);
    n_checks++; if (!ok) $display("FAIL match_success: got state %0d want 3", state); else n_pass++;
    n_checks++; if (found_idx !== 8'd2) $display("FAIL match_found: got %0d want 2", found_idx); else n_pass++;
    n_checks++; if (rd_n - r0 != 6) $display("FAIL match_nreads: got %0d want 6", rd_n - r0); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (rd_log[8'(r0 + i)] !== 8'(i)) $display("FAIL match_addr%0d: got %0d want %0d", i, rd_log[8'(r0 + i)], i); else n_pass++;
    end
    n_checks++; if (n_start - s0 != 4) $display("FAIL match_nstart: got %0d want 4", n_start - s0); else n_pass++;
    n_checks++; if (last_dec !== 1'b0 || last_data !== mem[5]) $display("FAIL match_req: dec %b data %h want 0 %h", last_dec, last_data, mem[5]); else n_pass++;
    $display("dict_match: state=%0d found_idx=%0d reads=%0d starts=%0d", state, found_idx, rd_n - r0, n_start - s0);
  endtask

  task automatic test_no_match();
    int s0, r0;
    bit ok, seen;
    dec_result = ~KPT; match_en = 1'b0;
    s0 = n_start; r0 = rd_n;
    pulse_start();
    wait_state(3'd4, 300, ok);
    n_checks++; if (!ok) $display("FAIL nomatch_fail: got state %0d want 4", state); else n_pass++;
    n_checks++; if (led !== 3'b001) $display("FAIL nomatch_led: got %b want 001", led); else n_pass++;
    n_checks++; if (found_idx !== 8'h00) $display("FAIL nomatch_found: got %h want 00", found_idx); else n_pass++;
    n_checks++; if (rd_n - r0 != 7) $display("FAIL nomatch_nreads: got %0d want 7", rd_n - r0); else n_pass++;
    for (int i = 3; i < 7; i++) begin
      n_checks++; if (rd_log[8'(r0 + i)] !== 8'(i)) $display("FAIL nomatch_addr%0d: got %0d want %0d", i, rd_log[8'(r0 + i)], i); else n_pass++;
    end
    n_checks++; if (n_start - s0 != 5) $display("FAIL nomatch_nstart: got %0d want 5", n_start - s0); else n_pass++;
    n_checks++; if (last_data !== mem[6]) $display("FAIL nomatch_lastword: got %h want %h", last_data, mem[6]); else n_pass++;
    pulse_start();
    n_checks++; if (state !== 3'd0 || led !== 3'b011) $display("FAIL restart_state: state %0d led %b want 0 011", state, led); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen || bus.mem_addr !== 8'd0) $display("FAIL restart_read: mem_en seen %b addr %0d want 1 0", seen, bus.mem_addr); else n_pass++;
    wait_state(3'd4, 300, ok);
    n_checks++; if (!ok) $display("FAIL restart_settle: got state %0d want 4", state); else n_pass++;
    $display("no_match: state=%0d led=%b reads=%0d starts=%0d", state, led, rd_n - r0, n_start - s0);
  endtask

  task automatic test_reset_mid_sweep();
    int s0;
    bit seen;
    dec_result = ~KPT; match_en = 1'b0; aes_lat = 6;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.aes_start === 1'b1 && bus.aes_decrypt === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL midreset_enc: encrypt request never seen, state %0d", state); else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_checks++; if (state !== 3'd0 || led !== 3'b000) $display("FAIL midreset_out: state %0d led %b want 0 000", state, led); else n_pass++;
    n_checks++; if (bus.aes_start !== 1'b0 || bus.mem_en !== 1'b0) $display("FAIL midreset_strobe: aes_start %b mem_en %b want 0 0", bus.aes_start, bus.mem_en); else n_pass++;
    reset = 1'b0;
    s0 = n_start;
    repeat (12) @(negedge clk);
    n_checks++; if (n_start != s0) $display("FAIL midreset_nostart: got %0d starts want 0", n_start - s0); else n_pass++;
    n_checks++; if (state !== 3'd0 || led !== 3'b011) $display("FAIL midreset_late_done: state %0d led %b want 0 011", state, led); else n_pass++;
    aes_lat = 3;
    $display("reset_mid_sweep: state=%0d led=%b", state, led);
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    aes_mute = 1'b1; dec_result = ~KPT;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.aes_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) $display("FAIL tmo_start: aes_start never seen"); else n_pass++;
`ifdef AES_TIMEOUT_EN
    k = 0;
    while (state !== 3'd4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (k != 16) $display("FAIL tmo_cycles: got %0d want 16", k); else n_pass++;
    n_checks++; if (timeout !== 1'b1 || led !== 3'b001) $display("FAIL tmo_flag: timeout %b led %b want 1 001", timeout, led); else n_pass++;
    pulse_start();
    n_checks++; if (timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", timeout); else n_pass++;
`else
    k = 40;
    repeat (40) @(negedge clk);
    n_checks++; if (state !== 3'd1 || timeout !== 1'b0) $display("FAIL tmo_wait: state %0d timeout %b want 1 0", state, timeout); else n_pass++;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    aes_mute = 1'b0;
    @(negedge clk);
    $display("timeout: waited=%0d state=%0d", k, state);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = {8'hEE, 112'h0, 8'(i)};
    mem[0] = HASH; mem[1] = KEY; mem[2] = CT;
    mem[3] = 128'hA0A0A0A0_A0A0A0A0_A0A0A0A0_A0A0A0A0;
    mem[4] = 128'hA1A1A1A1_A1A1A1A1_A1A1A1A1_A1A1A1A1;
    mem[5] = 128'hA2A2A2A2_A2A2A2A2_A2A2A2A2_A2A2A2A2;
    mem[6] = 128'hA3A3A3A3_A3A3A3A3_A3A3A3A3_A3A3A3A3;
    test_reset();
    test_trial_decrypt();
    test_dict_match();
    test_no_match();
    test_reset_mid_sweep();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
